// File: rtl/axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter
//
// Round-robin arbiter for the AXI write channels (AW/W/B). NUM_M masters
// share a single slave write port. Only one write burst is in flight at a
// time: the owning master is chosen in IDLE and keeps the grant from its
// AW handshake, through its W beats, until the B handshake completes.
//
// Parameters
//   NUM_M   number of requesting masters (2..8)
//   ADDR_W  address width
//   DATA_W  data width, strobe width is DATA_W/8
//   ID_W    AWID/BID width
//
// Ports
//   clk                       clock, everything on the rising edge
//   rst                       synchronous reset, active-low (0 = reset)
//   m_awaddr/m_awid/m_awlen   packed per-master AW payload, master i at [i*W +: W]
//   m_awvalid/m_awready       per-master AW handshake
//   m_wdata/m_wstrb/m_wlast   packed per-master W payload
//   m_wvalid/m_wready         per-master W handshake
//   m_bid/m_bresp             B payload broadcast to every master
//   m_bvalid/m_bready         per-master B handshake
//   s_aw*/s_w*/s_b*           slave-side write port (payload muxed from owner)
//   grant                     one-hot current owner, all zero in IDLE
//   busy                      high whenever a burst is being arbitrated/served
// ---------------------------------------------------------------------------
module axi_wr_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    // Master-side AW channel
    input  logic [NUM_M*ADDR_W-1:0]     m_awaddr,
    input  logic [NUM_M*ID_W-1:0]       m_awid,
    input  logic [NUM_M*8-1:0]          m_awlen,
    input  logic [NUM_M-1:0]            m_awvalid,
    output logic [NUM_M-1:0]            m_awready,

    // Master-side W channel
    input  logic [NUM_M*DATA_W-1:0]     m_wdata,
    input  logic [NUM_M*(DATA_W/8)-1:0] m_wstrb,
    input  logic [NUM_M-1:0]            m_wlast,
    input  logic [NUM_M-1:0]            m_wvalid,
    output logic [NUM_M-1:0]            m_wready,

    // Master-side B channel
    output logic [NUM_M*ID_W-1:0]       m_bid,
    output logic [NUM_M*2-1:0]          m_bresp,
    output logic [NUM_M-1:0]            m_bvalid,
    input  logic [NUM_M-1:0]            m_bready,

    // Slave-side AW channel
    output logic [ADDR_W-1:0]           s_awaddr,
    output logic [ID_W-1:0]             s_awid,
    output logic [7:0]                  s_awlen,
    output logic                        s_awvalid,
    input  logic                        s_awready,

    // Slave-side W channel
    output logic [DATA_W-1:0]           s_wdata,
    output logic [DATA_W/8-1:0]         s_wstrb,
    output logic                        s_wlast,
    output logic                        s_wvalid,
    input  logic                        s_wready,

    // Slave-side B channel
    input  logic [ID_W-1:0]             s_bid,
    input  logic [1:0]                  s_bresp,
    input  logic                        s_bvalid,
    output logic                        s_bready,

    // Status
    output logic [NUM_M-1:0]            grant,
    output logic                        busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   gidx;       // index of the owner, 0 while IDLE
    logic [IDX_W-1:0]   ptr;        // last master that completed a burst
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand_idx;
    logic               req_any;
    int                 cand;

    logic               aw_hs;
    logic               w_last_hs;
    logic               b_hs;

    // Round-robin search: the master right after the previous winner has
    // highest priority, so a master that was just served goes to the back
    // of the line while anybody else is still waiting.
    always_comb begin
        winner   = '0;
        req_any  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            cand     = (int'(ptr) + k) % NUM_M;
            cand_idx = IDX_W'(cand);
            if (!req_any && m_awvalid[cand_idx]) begin
                req_any = 1'b1;
                winner  = cand_idx;
            end
        end
    end

    // Slave-side payload is a plain mux of the owner's signals. While IDLE
    // gidx is 0, so master 0's payload shows through; the valids are low
    // then, so nothing downstream acts on it.
    always_comb begin
        s_awaddr = m_awaddr[int'(gidx)*ADDR_W +: ADDR_W];
        s_awid   = m_awid[int'(gidx)*ID_W +: ID_W];
        s_awlen  = m_awlen[int'(gidx)*8 +: 8];
        s_wdata  = m_wdata[int'(gidx)*DATA_W +: DATA_W];
        s_wstrb  = m_wstrb[int'(gidx)*STRB_W +: STRB_W];
        s_wlast  = m_wlast[gidx];
    end

    // Handshake signals only pass through for the owner and only while the
    // FSM sits in the phase for that channel. This is what stalls early W
    // beats: a master may raise wvalid before its AW is accepted, but it
    // sees wready=0 until the arbiter has reached DATA.
    always_comb begin
        s_awvalid = (state == ADDR) && m_awvalid[gidx];
        s_wvalid  = (state == DATA) && m_wvalid[gidx];
        s_bready  = (state == RESP) && m_bready[gidx];

        m_awready = (state == ADDR && s_awready) ? grant : '0;
        m_wready  = (state == DATA && s_wready)  ? grant : '0;
        m_bvalid  = (state == RESP && s_bvalid)  ? grant : '0;

        m_bid     = {NUM_M{s_bid}};
        m_bresp   = {NUM_M{s_bresp}};

        busy      = (state != IDLE);
    end

    // Handshake completion strobes used by the FSM.
    always_comb begin
        aw_hs     = s_awvalid && s_awready;
        w_last_hs = s_wvalid && s_wready && s_wlast;
        b_hs      = s_bvalid && s_bready;
    end

    // Main FSM. The grant is taken in IDLE and held until the write response
    // has been accepted; there is no preemption and no beat counting, the
    // data phase ends purely on WLAST. ptr resets to NUM_M-1 so master 0 is
    // first in line after reset. A reset in the middle of a burst simply
    // drops the transaction; masters are expected to reissue it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            ptr   <= IDX_W'(NUM_M - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant <= {{(NUM_M-1){1'b0}}, 1'b1} << winner;
                        gidx  <= winner;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (w_last_hs) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        ptr   <= gidx;
                        gidx  <= '0;
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    gidx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_arbiter
//
// Bench for axi_wr_arbiter with four masters. Master drivers and a simple
// slave model run as separate processes. Each scenario pushes the expected
// slave-side AW/W transfers and master-side B responses into queues in the
// order the round-robin arbiter must serve them; a monitor pops and checks
// on every observed handshake. A few cycle-exact checks (latency, stalls,
// reset) are made directly by the scenarios.
// ---------------------------------------------------------------------------
module tb_axi_wr_arbiter;

    localparam int NM      = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int IW      = 4;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst;

    logic [NM*AW-1:0] m_awaddr;
    logic [NM*IW-1:0] m_awid;
    logic [NM*8-1:0]  m_awlen;
    logic [NM-1:0]    m_awvalid;
    logic [NM-1:0]    m_awready;
    logic [NM*DW-1:0] m_wdata;
    logic [NM*SW-1:0] m_wstrb;
    logic [NM-1:0]    m_wlast;
    logic [NM-1:0]    m_wvalid;
    logic [NM-1:0]    m_wready;
    logic [NM*IW-1:0] m_bid;
    logic [NM*2-1:0]  m_bresp;
    logic [NM-1:0]    m_bvalid;
    logic [NM-1:0]    m_bready;

    logic [AW-1:0]    s_awaddr;
    logic [IW-1:0]    s_awid;
    logic [7:0]       s_awlen;
    logic             s_awvalid;
    logic             s_awready;
    logic [DW-1:0]    s_wdata;
    logic [SW-1:0]    s_wstrb;
    logic             s_wlast;
    logic             s_wvalid;
    logic             s_wready;
    logic [IW-1:0]    s_bid;
    logic [1:0]       s_bresp;
    logic             s_bvalid;
    logic             s_bready;
    logic [NM-1:0]    grant;
    logic             busy;

    // Per-master driver registers, packed onto the DUT buses below
    logic [AW-1:0] awaddr_r [NM];
    logic [IW-1:0] awid_r   [NM];
    logic [7:0]    awlen_r  [NM];
    logic          awvalid_r[NM];
    logic [DW-1:0] wdata_r  [NM];
    logic [SW-1:0] wstrb_r  [NM];
    logic          wlast_r  [NM];
    logic          wvalid_r [NM];
    logic          bready_r [NM];

    logic [1:0]    slaveResp;

    typedef struct {
        int            m;
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [7:0]    len;
    } aw_t;

    typedef struct {
        int            m;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } w_t;

    typedef struct {
        int            m;
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_t;

    aw_t expAw[$];
    w_t  expW[$];
    b_t  expB[$];

    int compared   = 0;
    int mismatched = 0;

    axi_wr_arbiter #(
        .NUM_M  (NM),
        .ADDR_W (AW),
        .DATA_W (DW),
        .ID_W   (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_awaddr  (m_awaddr),
        .m_awid    (m_awid),
        .m_awlen   (m_awlen),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wlast   (m_wlast),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bid     (m_bid),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .s_awaddr  (s_awaddr),
        .s_awid    (s_awid),
        .s_awlen   (s_awlen),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bid     (s_bid),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pack the per-master driver registers onto the DUT buses.
    always_comb begin
        m_awaddr  = '0;
        m_awid    = '0;
        m_awlen   = '0;
        m_awvalid = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = '0;
        m_wvalid  = '0;
        m_bready  = '0;
        for (int i = 0; i < NM; i++) begin
            m_awaddr[i*AW +: AW] = awaddr_r[i];
            m_awid[i*IW +: IW]   = awid_r[i];
            m_awlen[i*8 +: 8]    = awlen_r[i];
            m_awvalid[i]         = awvalid_r[i];
            m_wdata[i*DW +: DW]  = wdata_r[i];
            m_wstrb[i*SW +: SW]  = wstrb_r[i];
            m_wlast[i]           = wlast_r[i];
            m_wvalid[i]          = wvalid_r[i];
            m_bready[i]          = bready_r[i];
        end
    end

    // One comparison: counts it, and reports it if the values differ.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Queue the transfers one burst must produce, in service order.
    task automatic expectBurst(input int m, input logic [AW-1:0] addr,
                               input logic [IW-1:0] id, input int len,
                               input logic [DW-1:0] base, input logic [1:0] resp);
        aw_t a;
        w_t  w;
        b_t  b;
        a.m = m; a.addr = addr; a.id = id; a.len = 8'(len);
        expAw.push_back(a);
        for (int k = 0; k <= len; k++) begin
            w.m    = m;
            w.data = base + DW'(k);
            w.strb = 4'hF ^ 4'(k);
            w.last = (k == len);
            expW.push_back(w);
        end
        b.m = m; b.id = id; b.resp = resp;
        expB.push_back(b);
    endtask

    // Master driver: AW, then len+1 W beats, then accept B. With earlyW the
    // first W beat is already presented together with AWVALID.
    task automatic applyStimulus(input int m, input logic [AW-1:0] addr,
                                 input logic [IW-1:0] id, input int len,
                                 input logic [DW-1:0] base, input bit earlyW);
        int n;
        logic [1:0] mi;
        mi = 2'(m);
        awaddr_r[mi]  = addr;
        awid_r[mi]    = id;
        awlen_r[mi]   = 8'(len);
        awvalid_r[mi] = 1'b1;
        if (earlyW) begin
            wdata_r[mi]  = base;
            wstrb_r[mi]  = 4'hF;
            wlast_r[mi]  = (len == 0);
            wvalid_r[mi] = 1'b1;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!m_awready[mi] && n < TIMEOUT);
        if (!m_awready[mi]) begin
            checkOutput("aw_timeout", 64'(m), 64'(m + 100));
            awvalid_r[mi] = 1'b0;
            wvalid_r[mi]  = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid_r[mi] = 1'b0;
        for (int k = 0; k <= len; k++) begin
            wdata_r[mi]  = base + DW'(k);
            wstrb_r[mi]  = 4'hF ^ 4'(k);
            wlast_r[mi]  = (k == len);
            wvalid_r[mi] = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!m_wready[mi] && n < TIMEOUT);
            if (!m_wready[mi]) begin
                checkOutput("w_timeout", 64'(m), 64'(m + 100));
                wvalid_r[mi] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        wvalid_r[mi] = 1'b0;
        wlast_r[mi]  = 1'b0;
        bready_r[mi] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_bvalid[mi] && n < TIMEOUT);
        if (!m_bvalid[mi]) begin
            checkOutput("b_timeout", 64'(m), 64'(m + 100));
        end
        @(posedge clk); #1;
        bready_r[mi] = 1'b0;
    endtask

    // Two back-to-back bursts from one master, used by the all-request round.
    task automatic runTwo(input int m);
        for (int r = 0; r < 2; r++) begin
            applyStimulus(m, 32'h8000_0000 | AW'(m << 12) | AW'(r << 8), 4'(m + 4*r),
                          r, 32'hA000_0000 | DW'(m << 16) | DW'(r << 8), 1'b0);
        end
    endtask

    // Slave model: remembers the accepted AWID, raises BVALID the cycle after
    // the WLAST beat and drops it once the response is taken.
    initial begin
        logic          awHs, wLastHs, bHs;
        logic [IW-1:0] lastId;
        lastId   = '0;
        s_bvalid = 1'b0;
        s_bid    = '0;
        s_bresp  = 2'b00;
        forever begin
            @(negedge clk);
            awHs    = s_awvalid && s_awready;
            wLastHs = s_wvalid && s_wready && s_wlast;
            bHs     = s_bvalid && s_bready;
            if (awHs) lastId = s_awid;
            @(posedge clk); #1;
            if (bHs) s_bvalid = 1'b0;
            if (wLastHs) begin
                s_bvalid = 1'b1;
                s_bid    = lastId;
                s_bresp  = slaveResp;
            end
            if (!rst) s_bvalid = 1'b0;
        end
    end

    // Monitor: every handshake the DUT completes is matched against the
    // head of the corresponding expectation queue.
    initial begin
        aw_t ea;
        w_t  ew;
        b_t  eb;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (s_awvalid && s_awready) begin
                    if (expAw.size() == 0) begin
                        checkOutput("aw_unexpected", 64'(s_awaddr), 64'h0);
                    end else begin
                        ea = expAw.pop_front();
                        checkOutput("aw_grant", 64'(grant), 64'(4'b0001 << ea.m));
                        checkOutput("aw_addr",  64'(s_awaddr), 64'(ea.addr));
                        checkOutput("aw_id",    64'(s_awid),   64'(ea.id));
                        checkOutput("aw_len",   64'(s_awlen),  64'(ea.len));
                    end
                end
                if (s_wvalid && s_wready) begin
                    if (expW.size() == 0) begin
                        checkOutput("w_unexpected", 64'(s_wdata), 64'h0);
                    end else begin
                        ew = expW.pop_front();
                        checkOutput("w_grant", 64'(grant),   64'(4'b0001 << ew.m));
                        checkOutput("w_data",  64'(s_wdata), 64'(ew.data));
                        checkOutput("w_strb",  64'(s_wstrb), 64'(ew.strb));
                        checkOutput("w_last",  64'(s_wlast), 64'(ew.last));
                    end
                end
                for (int i = 0; i < NM; i++) begin
                    if (m_bvalid[2'(i)] && m_bready[2'(i)]) begin
                        if (expB.size() == 0) begin
                            checkOutput("b_unexpected", 64'(i), 64'hFF);
                        end else begin
                            eb = expB.pop_front();
                            checkOutput("b_master", 64'(i), 64'(eb.m));
                            checkOutput("b_id",   64'(m_bid[i*IW +: IW]), 64'(eb.id));
                            checkOutput("b_resp", 64'(m_bresp[i*2 +: 2]), 64'(eb.resp));
                        end
                    end
                end
            end
        end
    end

    // Hard stop in case something gets stuck outside the bounded waits.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset-state check of every handshake output.
    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_grant"},     64'(grant),     64'h0);
        checkOutput({tag, "_busy"},      64'(busy),      64'h0);
        checkOutput({tag, "_s_awvalid"}, 64'(s_awvalid), 64'h0);
        checkOutput({tag, "_s_wvalid"},  64'(s_wvalid),  64'h0);
        checkOutput({tag, "_s_bready"},  64'(s_bready),  64'h0);
        checkOutput({tag, "_m_awready"}, 64'(m_awready), 64'h0);
        checkOutput({tag, "_m_wready"},  64'(m_wready),  64'h0);
        checkOutput({tag, "_m_bvalid"},  64'(m_bvalid),  64'h0);
    endtask

    initial begin
        int n;
        rst       = 1'b0;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        slaveResp = 2'b00;
        for (int i = 0; i < NM; i++) begin
            awaddr_r[i] = '0; awid_r[i] = '0; awlen_r[i] = '0; awvalid_r[i] = 1'b0;
            wdata_r[i]  = '0; wstrb_r[i] = '0; wlast_r[i] = 1'b0; wvalid_r[i] = 1'b0;
            bready_r[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkQuiet("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Single master 1, AWLEN=3, OKAY; AW reaches the slave one cycle later.
        $display("[TB] single master 1 burst");
        expectBurst(1, 32'h0000_1000, 4'h5, 3, 32'h1100_0000, 2'b00);
        fork
            applyStimulus(1, 32'h0000_1000, 4'h5, 3, 32'h1100_0000, 1'b0);
            begin
                @(negedge clk);
                checkOutput("lat_idle_awvalid", 64'(s_awvalid), 64'h0);
                checkOutput("lat_idle_grant",   64'(grant),     64'h0);
                @(negedge clk);
                checkOutput("lat_addr_awvalid", 64'(s_awvalid), 64'h1);
                checkOutput("lat_addr_grant",   64'(grant),     64'h2);
                checkOutput("lat_addr_busy",    64'(busy),      64'h1);
            end
        join
        @(negedge clk);
        checkOutput("post_burst_grant", 64'(grant), 64'h0);
        checkOutput("post_burst_busy",  64'(busy),  64'h0);
        @(posedge clk); #1;

        // Masters 0 and 1 together, twice: served 0,1,0,1.
        $display("[TB] masters 0 and 1 alternate");
        slaveResp = 2'b01;
        for (int r = 0; r < 2; r++) begin
            expectBurst(0, 32'h0000_2000 + AW'(r*16), 4'h1, 1, 32'h2000_0000 + DW'(r*256), 2'b01);
            expectBurst(1, 32'h0000_3000 + AW'(r*16), 4'h2, 1, 32'h2100_0000 + DW'(r*256), 2'b01);
        end
        for (int r = 0; r < 2; r++) begin
            fork
                applyStimulus(0, 32'h0000_2000 + AW'(r*16), 4'h1, 1, 32'h2000_0000 + DW'(r*256), 1'b0);
                applyStimulus(1, 32'h0000_3000 + AW'(r*16), 4'h2, 1, 32'h2100_0000 + DW'(r*256), 1'b0);
            join
        end
        @(posedge clk); #1;

        // Masters 2 and 3 together; slave stalls WREADY 3 cycles in master 2's burst.
        $display("[TB] slave W backpressure");
        slaveResp = 2'b00;
        expectBurst(2, 32'h0000_4000, 4'h3, 3, 32'h3300_0000, 2'b00);
        expectBurst(3, 32'h0000_4800, 4'h4, 0, 32'h3400_0000, 2'b00);
        fork
            applyStimulus(2, 32'h0000_4000, 4'h3, 3, 32'h3300_0000, 1'b0);
            applyStimulus(3, 32'h0000_4800, 4'h4, 0, 32'h3400_0000, 1'b0);
            begin
                n = 0;
                do begin @(negedge clk); n++; end
                while (!(s_wvalid && s_wready && grant == 4'b0100) && n < TIMEOUT);
                checkOutput("stall_reach_data", 64'(grant), 64'h4);
                @(posedge clk); #1;
                s_wready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall_m_wready", 64'(m_wready), 64'h0);
                    checkOutput("stall_wdata",    64'(s_wdata),  64'h3300_0001);
                    checkOutput("stall_wvalid",   64'(s_wvalid), 64'h1);
                end
                @(posedge clk); #1;
                s_wready = 1'b1;
            end
        join
        @(posedge clk); #1;

        // Master 1 presents W before its AW is granted.
        $display("[TB] early W beats held off");
        expectBurst(1, 32'h0000_6000, 4'h6, 1, 32'h6600_0000, 2'b00);
        fork
            applyStimulus(1, 32'h0000_6000, 4'h6, 1, 32'h6600_0000, 1'b1);
            begin
                @(negedge clk);
                checkOutput("early_idle_m_wready", 64'(m_wready), 64'h0);
                checkOutput("early_idle_s_wvalid", 64'(s_wvalid), 64'h0);
                @(negedge clk);
                checkOutput("early_addr_grant",    64'(grant),    64'h2);
                checkOutput("early_addr_m_wready", 64'(m_wready), 64'h0);
                checkOutput("early_addr_s_wvalid", 64'(s_wvalid), 64'h0);
            end
        join
        @(posedge clk); #1;

        // Reset during DATA abandons the burst; a new request is served after.
        $display("[TB] reset in data phase");
        s_wready = 1'b0;
        expAw.push_back('{m: 2, addr: 32'h0000_5000, id: 4'h9, len: 8'd7});
        awaddr_r[2] = 32'h0000_5000; awid_r[2] = 4'h9; awlen_r[2] = 8'd7; awvalid_r[2] = 1'b1;
        wdata_r[2] = 32'h5555_0000; wstrb_r[2] = 4'hF; wlast_r[2] = 1'b0; wvalid_r[2] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(busy && s_wvalid) && n < TIMEOUT);
        checkOutput("rst_pre_grant", 64'(grant), 64'h4);
        awvalid_r[2] = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkQuiet("midrst");
        wvalid_r[2] = 1'b0;
        rst = 1'b1;
        s_wready = 1'b1;
        @(posedge clk); #1;
        expectBurst(2, 32'h0000_5100, 4'hA, 1, 32'h5600_0000, 2'b00);
        applyStimulus(2, 32'h0000_5100, 4'hA, 1, 32'h5600_0000, 1'b0);
        @(posedge clk); #1;

        // After a fresh reset all four masters request continuously: 0,1,2,3,0,1,2,3.
        $display("[TB] four masters, eight bursts");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        slaveResp = 2'b10;
        for (int r = 0; r < 2; r++) begin
            for (int m = 0; m < NM; m++) begin
                expectBurst(m, 32'h8000_0000 | AW'(m << 12) | AW'(r << 8), 4'(m + 4*r),
                            r, 32'hA000_0000 | DW'(m << 16) | DW'(r << 8), 2'b10);
            end
        end
        fork
            runTwo(0);
            runTwo(1);
            runTwo(2);
            runTwo(3);
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("aw_queue_drained", 64'(expAw.size()), 64'h0);
        checkOutput("w_queue_drained",  64'(expW.size()),  64'h0);
        checkOutput("b_queue_drained",  64'(expB.size()),  64'h0);
        checkOutput("final_busy",       64'(busy),         64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
